// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcodes, funct codes, ALU encodings, the control bundle and FSM state
// shared by ctrl_pipe (optional forwarding info enabled by CTRL_FWD_INFO_EN).
package ctrl_pkg;
  localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000, OP_LW = 6'b100011,
                         OP_LB = 6'b100101, OP_SW = 6'b101011, OP_BEQ = 6'b000100,
                         OP_J = 6'b000010;
  localparam logic [5:0] FN_ADD = 6'b100000, FN_SUB = 6'b100010, FN_AND = 6'b100100,
                         FN_X3 = 6'b011110, FN_OR = 6'b100101, FN_SLT = 6'b101010,
                         FN_MULT = 6'b011000;
  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2, ALU_X3 = 3'd3,
                         ALU_OR = 3'd4, ALU_SLT = 3'd5, ALU_MUL = 3'd6;
  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic       branch_eq;
    logic       jump;
    logic       alu_src;
    logic       load_ctrl;
    logic [2:0] alu;
  } ctrl_t;
  localparam ctrl_t CTRL_NOP = '0;
  typedef enum logic {IDLE, BUSY} state_t;
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational op/funct to control bundle decoder used in ID.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output ctrl_t      ctrl_o,
  output logic       is_r_o,
  output logic       is_mult_o,
  output logic       reads_rt_o
);
  always_comb begin
    ctrl_o = CTRL_NOP;
    is_mult_o = 1'b0;
    is_r_o = op_i == OP_R;
    reads_rt_o = op_i inside {OP_R, OP_SW, OP_BEQ};
    case (op_i)
      OP_R: begin
        ctrl_o.reg_write = 1'b1;
        case (funct_i)
          FN_ADD:  ctrl_o.alu = ALU_ADD;
          FN_SUB:  ctrl_o.alu = ALU_SUB;
          FN_AND:  ctrl_o.alu = ALU_AND;
          FN_X3:   ctrl_o.alu = ALU_X3;
          FN_OR:   ctrl_o.alu = ALU_OR;
          FN_SLT:  ctrl_o.alu = ALU_SLT;
          FN_MULT: begin
            ctrl_o.alu = ALU_MUL;
            is_mult_o = 1'b1;
          end
          default: ctrl_o.reg_write = 1'b0;
        endcase
      end
      OP_ADDI: {ctrl_o.alu_src, ctrl_o.reg_write} = 2'b11;
      OP_LW, OP_LB: begin
        {ctrl_o.alu_src, ctrl_o.mem_to_reg, ctrl_o.reg_write} = 3'b111;
        ctrl_o.load_ctrl = op_i == OP_LB;
      end
      OP_SW: {ctrl_o.alu_src, ctrl_o.mem_write} = 2'b11;
      OP_BEQ: begin
        ctrl_o.branch_eq = 1'b1;
        ctrl_o.alu = ALU_SUB;
      end
      OP_J: ctrl_o.jump = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: pipelined control decode with load-use/RAW interlock and multi-cycle MULT FSM.
// CTRL_FWD_INFO_EN adds forwarding-select outputs and limits stalls to load-use.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int ALUC_W = 4,
  parameter int MUL_LAT = 4,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        op,
  input  logic [5:0]        funct,
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  input  logic [REG_AW-1:0] rd,
  input  logic              id_valid,
  input  logic              ex_flush,
  output logic              stall,
  output logic              mul_busy,
  output logic              ex_valid, ex_RegWrite, ex_MemToReg, ex_MemWrite,
  output logic              ex_BranchEq, ex_Jump, ex_ALUSrc, ex_LoadCtrl,
  output logic [ALUC_W-1:0] ex_ALUc,
  output logic [REG_AW-1:0] ex_wreg,
  output logic              mem_valid, mem_RegWrite, mem_MemToReg, mem_MemWrite, mem_LoadCtrl,
  output logic [REG_AW-1:0] mem_wreg,
  output logic              wb_valid, wb_RegWrite, wb_MemToReg, wb_LoadCtrl,
`ifdef CTRL_FWD_INFO_EN
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
`endif
  output logic [REG_AW-1:0] wb_wreg
);
  localparam int CW = MUL_LAT > 1 ? $clog2(MUL_LAT) : 1;
  ctrl_t dec, id_c, ex_q, ex_d;
  logic is_r, is_mult, reads_rt, busy, hazard, load_ex, ld, mul_start;
  logic [REG_AW-1:0] id_wreg, ex_wreg_q, ex_wreg_d, mem_wreg_q, wb_wreg_q;
  logic ex_valid_q, ex_valid_d;
  logic mem_valid_q, mem_rw_q, mem_mtr_q, mem_mw_q, mem_lc_q;
  logic wb_valid_q, wb_rw_q, wb_mtr_q, wb_lc_q;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  function automatic logic raw(input logic w, input logic [REG_AW-1:0] a, s, t, input logic use_t);
    return w & (a != '0) & ((a == s) | ((a == t) & use_t));
  endfunction
  ctrl_decode u_dec (.op_i(op), .funct_i(funct), .ctrl_o(dec), .is_r_o(is_r), .is_mult_o(is_mult), .reads_rt_o(reads_rt));
  always_comb begin
    id_wreg = is_r ? rd : rt;
    id_c = dec;
    id_c.reg_write = dec.reg_write & id_valid & ~is_mult & (id_wreg != '0);
  end
  assign busy = state_q == BUSY;
`ifdef CTRL_FWD_INFO_EN
  assign hazard = raw(ex_valid_q & ex_q.mem_to_reg, ex_wreg_q, rs, rt, reads_rt);
`else
  // Without forwarding, any pending writer in EX or MEM must drain before ID reads it.
  assign hazard = raw(ex_valid_q & ex_q.reg_write, ex_wreg_q, rs, rt, reads_rt) |
                  raw(mem_valid_q & mem_rw_q, mem_wreg_q, rs, rt, reads_rt);
`endif
  assign stall = busy | (hazard & ~ex_flush);
  assign mul_busy = busy;
  always_comb begin
    load_ex = ~busy & ~hazard & ~ex_flush;
    ld = load_ex & id_valid;
    mul_start = ld & is_mult & (MUL_LAT > 1);
    state_d = busy ? ((cnt_q == CW'(1)) ? IDLE : BUSY) : (mul_start ? BUSY : IDLE);
    cnt_d = busy ? cnt_q - CW'(1) : (mul_start ? CW'(MUL_LAT - 1) : '0);
    ex_valid_d = busy ? ex_valid_q : ld;
    ex_d = busy ? ex_q : (ld ? id_c : CTRL_NOP);
    ex_wreg_d = busy ? ex_wreg_q : (ld ? id_wreg : '0);
  end
`ifdef CTRL_FWD_INFO_EN
  logic [REG_AW-1:0] ex_rs_q, ex_rt_q;
  function automatic logic [1:0] fwd(input logic [REG_AW-1:0] r);
    return (mem_rw_q & (mem_wreg_q != '0) & (mem_wreg_q == r)) ? 2'b01 :
           (wb_rw_q & (wb_wreg_q != '0) & (wb_wreg_q == r)) ? 2'b10 : 2'b00;
  endfunction
  assign fwd_a = fwd(ex_rs_q);
  assign fwd_b = fwd(ex_rt_q);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ex_rs_q <= '0;
      ex_rt_q <= '0;
    end else if (!busy) begin
      ex_rs_q <= ld ? rs : '0;
      ex_rt_q <= ld ? rt : '0;
    end
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      ex_valid_q <= 1'b0;
      ex_q <= CTRL_NOP;
      ex_wreg_q <= '0;
      {mem_valid_q, mem_rw_q, mem_mtr_q, mem_mw_q, mem_lc_q} <= '0;
      mem_wreg_q <= '0;
      {wb_valid_q, wb_rw_q, wb_mtr_q, wb_lc_q} <= '0;
      wb_wreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ex_valid_q <= ex_valid_d;
      ex_q <= ex_d;
      ex_wreg_q <= ex_wreg_d;
      {mem_valid_q, mem_rw_q, mem_mtr_q, mem_mw_q, mem_lc_q} <= busy ? 5'b0 :
        {ex_valid_q, ex_q.reg_write, ex_q.mem_to_reg, ex_q.mem_write, ex_q.load_ctrl};
      mem_wreg_q <= busy ? '0 : ex_wreg_q;
      {wb_valid_q, wb_rw_q, wb_mtr_q, wb_lc_q} <= {mem_valid_q, mem_rw_q, mem_mtr_q, mem_lc_q};
      wb_wreg_q <= mem_wreg_q;
    end
  assign ex_valid = ex_valid_q;
  assign {ex_RegWrite, ex_MemToReg, ex_MemWrite, ex_BranchEq, ex_Jump, ex_ALUSrc, ex_LoadCtrl} =
    {ex_q.reg_write, ex_q.mem_to_reg, ex_q.mem_write, ex_q.branch_eq, ex_q.jump, ex_q.alu_src, ex_q.load_ctrl};
  assign ex_ALUc = ALUC_W'(ex_q.alu);
  assign ex_wreg = ex_wreg_q;
  assign {mem_valid, mem_RegWrite, mem_MemToReg, mem_MemWrite, mem_LoadCtrl} =
    {mem_valid_q, mem_rw_q, mem_mtr_q, mem_mw_q, mem_lc_q};
  assign mem_wreg = mem_wreg_q;
  assign {wb_valid, wb_RegWrite, wb_MemToReg, wb_LoadCtrl} = {wb_valid_q, wb_rw_q, wb_mtr_q, wb_lc_q};
  assign wb_wreg = wb_wreg_q;
endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed self-checking bench for ctrl_pipe (default MUL_LAT=4).
module tb_ctrl_pipe;
  logic clk, rst;
  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd;
  logic id_valid, ex_flush;
  logic stall, mul_busy;
  logic ex_valid, ex_RegWrite, ex_MemToReg, ex_MemWrite, ex_BranchEq, ex_Jump, ex_ALUSrc, ex_LoadCtrl;
  logic [3:0] ex_ALUc;
  logic [4:0] ex_wreg, mem_wreg, wb_wreg;
  logic mem_valid, mem_RegWrite, mem_MemToReg, mem_MemWrite, mem_LoadCtrl;
  logic wb_valid, wb_RegWrite, wb_MemToReg, wb_LoadCtrl;
`ifdef CTRL_FWD_INFO_EN
  logic [1:0] fwd_a, fwd_b;
`endif
  int total = 0;
  int bad = 0;

  localparam logic [5:0] R = 6'b000000, ADDI = 6'b001000, LW = 6'b100011, LB = 6'b100101,
                         SW = 6'b101011, BEQ = 6'b000100, J = 6'b000010;
  localparam logic [5:0] F_ADD = 6'b100000, F_MULT = 6'b011000, F_BAD = 6'b111111;

  ctrl_pipe dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .rs(rs), .rt(rt), .rd(rd),
    .id_valid(id_valid), .ex_flush(ex_flush), .stall(stall), .mul_busy(mul_busy),
    .ex_valid(ex_valid), .ex_RegWrite(ex_RegWrite), .ex_MemToReg(ex_MemToReg),
    .ex_MemWrite(ex_MemWrite), .ex_BranchEq(ex_BranchEq), .ex_Jump(ex_Jump),
    .ex_ALUSrc(ex_ALUSrc), .ex_LoadCtrl(ex_LoadCtrl), .ex_ALUc(ex_ALUc), .ex_wreg(ex_wreg),
    .mem_valid(mem_valid), .mem_RegWrite(mem_RegWrite), .mem_MemToReg(mem_MemToReg),
    .mem_MemWrite(mem_MemWrite), .mem_LoadCtrl(mem_LoadCtrl), .mem_wreg(mem_wreg),
    .wb_valid(wb_valid), .wb_RegWrite(wb_RegWrite), .wb_MemToReg(wb_MemToReg),
    .wb_LoadCtrl(wb_LoadCtrl),
`ifdef CTRL_FWD_INFO_EN
    .fwd_a(fwd_a), .fwd_b(fwd_b),
`endif
    .wb_wreg(wb_wreg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [5:0] o, f, input logic [4:0] s, t, d, input logic v, fl);
    op = o; funct = f; rs = s; rt = t; rd = d; id_valid = v; ex_flush = fl;
    #1;
  endtask

  task automatic idle();
    drive(R, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) tick();
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_stall", stall, 0);
    chk("rst_mul_busy", mul_busy, 0);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_wb_wreg", wb_wreg, 0);
    rst = 1'b0;
    tick();

    drive(ADDI, 6'd0, 5'd0, 5'd8, 5'd0, 1'b1, 1'b0);
    tick();
    idle();
    chk("addi_ex_rw", ex_RegWrite, 1);
    chk("addi_ex_src", ex_ALUSrc, 1);
    chk("addi_ex_wreg", ex_wreg, 8);
    chk("addi_ex_aluc", ex_ALUc, 0);
    tick();
    chk("addi_mem_wreg", mem_wreg, 8);
    tick();
    chk("addi_wb_rw", wb_RegWrite, 1);
    chk("addi_wb_wreg", wb_wreg, 8);
    repeat (2) tick();

    drive(LW, 6'd0, 5'd0, 5'd9, 5'd0, 1'b1, 1'b0);
    tick();
    drive(R, F_ADD, 5'd9, 5'd0, 5'd10, 1'b1, 1'b0);
    chk("lu_stall", stall, 1);
    chk("lu_ex_mtr", ex_MemToReg, 1);
    tick();
    chk("lu_bubble", ex_valid, 0);
    chk("lu_mem_mtr", mem_MemToReg, 1);
`ifdef CTRL_FWD_INFO_EN
    chk("lu_stall_end", stall, 0);
`else
    chk("raw_mem_stall", stall, 1);
    tick();
    chk("raw_bubble2", ex_valid, 0);
    chk("lu_stall_end", stall, 0);
`endif
    tick();
    idle();
    chk("add_ex_valid", ex_valid, 1);
    chk("add_ex_aluc", ex_ALUc, 0);
    chk("add_ex_wreg", ex_wreg, 10);
    chk("add_ex_rw", ex_RegWrite, 1);
`ifdef CTRL_FWD_INFO_EN
    chk("add_fwd_a", fwd_a, 2);
`endif
    repeat (3) tick();

    drive(R, F_MULT, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
    chk("mul_pre_stall", stall, 0);
    tick();
    idle();
    chk("mul_busy1", mul_busy, 1);
    chk("mul_stall1", stall, 1);
    chk("mul_aluc", ex_ALUc, 6);
    chk("mul_ex_rw", ex_RegWrite, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("mul_busy_n", mul_busy, 1);
      chk("mul_stall_n", stall, 1);
      chk("mul_mem_bubble", mem_valid, 0);
    end
    tick();
    chk("mul_done_busy", mul_busy, 0);
    chk("mul_done_stall", stall, 0);
    chk("mul_hold_aluc", ex_ALUc, 6);
    chk("mul_hold_mem", mem_valid, 0);
    tick();
    chk("mul_mem_valid", mem_valid, 1);
    chk("mul_mem_rw", mem_RegWrite, 0);
    chk("mul_ex_next", ex_valid, 0);
    repeat (3) tick();

    drive(LW, 6'd0, 5'd0, 5'd9, 5'd0, 1'b1, 1'b0);
    tick();
    drive(R, F_ADD, 5'd9, 5'd0, 5'd10, 1'b1, 1'b1);
    chk("flush_stall", stall, 0);
    tick();
    idle();
    chk("flush_ex_valid", ex_valid, 0);
    chk("flush_mem_mtr", mem_MemToReg, 1);
    repeat (3) tick();

    drive(R, F_BAD, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
    tick();
    drive(ADDI, 6'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    chk("badfn_ex_valid", ex_valid, 1);
    chk("badfn_ex_rw", ex_RegWrite, 0);
    chk("badfn_ex_mw", ex_MemWrite, 0);
    tick();
    idle();
    chk("addi0_ex_rw", ex_RegWrite, 0);
    chk("badfn_mem_rw", mem_RegWrite, 0);
    tick();
    chk("addi0_mem_rw", mem_RegWrite, 0);
    chk("badfn_wb_rw", wb_RegWrite, 0);
    tick();
    chk("addi0_wb_rw", wb_RegWrite, 0);
    chk("addi0_wb_valid", wb_valid, 1);
    repeat (2) tick();

    drive(SW, 6'd0, 5'd0, 5'd4, 5'd0, 1'b1, 1'b0);
    tick();
    drive(BEQ, 6'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    chk("sw_ex_mw", ex_MemWrite, 1);
    chk("sw_ex_rw", ex_RegWrite, 0);
    chk("sw_ex_src", ex_ALUSrc, 1);
    tick();
    drive(LB, 6'd0, 5'd0, 5'd7, 5'd0, 1'b1, 1'b0);
    chk("beq_ex_br", ex_BranchEq, 1);
    chk("beq_ex_aluc", ex_ALUc, 1);
    chk("beq_ex_src", ex_ALUSrc, 0);
    chk("sw_mem_mw", mem_MemWrite, 1);
    tick();
    drive(J, 6'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    chk("lb_ex_lc", ex_LoadCtrl, 1);
    chk("lb_ex_mtr", ex_MemToReg, 1);
    chk("lb_ex_rw", ex_RegWrite, 1);
    tick();
    idle();
    chk("j_ex_jump", ex_Jump, 1);
    chk("lb_mem_lc", mem_LoadCtrl, 1);
    tick();
    chk("lb_wb_lc", wb_LoadCtrl, 1);
    chk("lb_wb_mtr", wb_MemToReg, 1);
    repeat (3) tick();

    drive(R, F_MULT, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
    tick();
    idle();
    tick();
    chk("rstmul_busy_pre", mul_busy, 1);
    rst = 1'b1;
    #1;
    chk("rstmul_busy", mul_busy, 0);
    chk("rstmul_stall", stall, 0);
    chk("rstmul_ex_valid", ex_valid, 0);
    chk("rstmul_mem_valid", mem_valid, 0);
    chk("rstmul_wb_valid", wb_valid, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_stall", stall, 0);
    chk("post_rst_busy", mul_busy, 0);
    chk("post_rst_ex_valid", ex_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
